// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage, instruction memory and decode.
// The master side is the fetch stage; the slave side is memory/decode.
interface fetch_stage_if;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        flush;
    logic        br_taken;
    logic [63:0] br_target;
    logic [31:0] id_instr;
    logic [63:0] id_pc;
    logic [63:0] id_pc_plus4;
    logic        id_valid;
    logic        fault;
    logic [63:0] fault_pc;

    modport master (
        output imem_addr, id_instr, id_pc, id_pc_plus4, id_valid, fault, fault_pc,
        input  imem_instr, stall, flush, br_taken, br_target
    );

    modport slave (
        input  imem_addr, id_instr, id_pc, id_pc_plus4, id_valid, fault, fault_pc,
        output imem_instr, stall, flush, br_taken, br_target
    );
endinterface

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: program counter, IF/ID pipeline register,
// stall/flush/redirect handling and a sticky misaligned-target fault.
module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    logic [63:0] pc_q, pc_d;
    logic [63:0] pc_plus4;
    logic [31:0] id_instr_q, id_instr_d;
    logic [63:0] id_pc_q, id_pc_d;
    logic [63:0] id_pc_plus4_q, id_pc_plus4_d;
    logic        id_valid_q, id_valid_d;
    logic        fault_q, fault_d;
    logic [63:0] fault_pc_q, fault_pc_d;

    always_comb begin
        // NOTE: every _d starts at its hold value so no path through this block infers a latch.
        pc_plus4      = pc_q + 64'd4;
        pc_d          = pc_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        id_valid_d    = id_valid_q;
        fault_d       = fault_q;
        fault_pc_d    = fault_pc_q;

        // A redirect outranks stall for both the PC and the IF/ID register.
        if (bus.br_taken)
            pc_d = {bus.br_target[63:2], 2'b00};
        else if (!bus.stall)
            pc_d = pc_plus4;

        if (bus.flush || bus.br_taken) begin
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
        end else if (!bus.stall) begin
            id_instr_d    = bus.imem_instr;
            id_pc_d       = pc_q;
            id_pc_plus4_d = pc_plus4;
            id_valid_d    = 1'b1;
        end

        // Only the first misaligned target is recorded; later ones keep the original.
        if (bus.br_taken && (bus.br_target[1:0] != 2'b00)) begin
            fault_d = 1'b1;
            if (!fault_q)
                fault_pc_d = bus.br_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            id_instr_q    <= NOP_INSTR;
            id_pc_q       <= 64'h0;
            id_pc_plus4_q <= 64'h0;
            id_valid_q    <= 1'b0;
            fault_q       <= 1'b0;
            fault_pc_q    <= 64'h0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            pc_q          <= pc_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_valid_q    <= id_valid_d;
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.id_instr    = id_instr_q;
    assign bus.id_pc       = id_pc_q;
    assign bus.id_pc_plus4 = id_pc_plus4_q;
    assign bus.id_valid    = id_valid_q;
    assign bus.fault       = fault_q;
    assign bus.fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage with RESET_PC = 0x100 and a
// small combinational instruction-memory model.
module tb_fetch_stage;

    localparam logic [63:0] RESET_PC  = 64'h100;
    localparam logic [31:0] NOP_INSTR = 32'hD503201F;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [63:0] a);
        if (a == 64'h100)      return 32'h8B020020;
        else if (a == 64'h104) return 32'h91000421;
        else                   return {4'hE, a[27:0]};
    endfunction

    assign bus.imem_instr = imem_word(bus.imem_addr);

    typedef struct {
        logic        stall;
        logic        flush;
        logic        br;
        logic [63:0] tgt;
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] id_pc;
        logic [63:0] id_pc4;
        logic        valid;
        logic        fault;
        logic [63:0] fault_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic f, input logic b, input logic [63:0] t,
                       input logic [63:0] pc, input logic [31:0] ins, input logic [63:0] ipc,
                       input logic [63:0] ipc4, input logic v, input logic flt,
                       input logic [63:0] fpc);
        vec_t e;
        e.stall = s; e.flush = f; e.br = b; e.tgt = t; e.pc = pc; e.instr = ins;
        e.id_pc = ipc; e.id_pc4 = ipc4; e.valid = v; e.fault = flt; e.fault_pc = fpc;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " imem_addr"},   bus.imem_addr,          RESET_PC);
        check({tag, " id_instr"},    {32'h0, bus.id_instr},  {32'h0, NOP_INSTR});
        check({tag, " id_pc"},       bus.id_pc,              64'h0);
        check({tag, " id_pc_plus4"}, bus.id_pc_plus4,        64'h0);
        check({tag, " id_valid"},    {63'h0, bus.id_valid},  64'h0);
        check({tag, " fault"},       {63'h0, bus.fault},     64'h0);
        check({tag, " fault_pc"},    bus.fault_pc,           64'h0);
    endtask

    initial begin
        // stall flush br target | pc instr id_pc id_pc4 valid fault fault_pc
        add(0,0,0,0,        64'h104, 32'h8B020020,     64'h100, 64'h104, 1, 0, 0);
        add(0,0,0,0,        64'h108, 32'h91000421,     64'h104, 64'h108, 1, 0, 0);
        add(1,0,0,0,        64'h108, 32'h91000421,     64'h104, 64'h108, 1, 0, 0);
        add(1,0,0,0,        64'h108, 32'h91000421,     64'h104, 64'h108, 1, 0, 0);
        add(1,0,0,0,        64'h108, 32'h91000421,     64'h104, 64'h108, 1, 0, 0);
        add(0,0,0,0,        64'h10C, imem_word(64'h108), 64'h108, 64'h10C, 1, 0, 0);
        add(0,0,0,0,        64'h110, imem_word(64'h10C), 64'h10C, 64'h110, 1, 0, 0);
        add(0,0,1,64'h40,   64'h040, NOP_INSTR,        64'h10C, 64'h110, 0, 0, 0);
        add(0,0,0,0,        64'h044, imem_word(64'h40),  64'h040, 64'h044, 1, 0, 0);
        add(1,0,1,64'h200,  64'h200, NOP_INSTR,        64'h040, 64'h044, 0, 0, 0);
        add(0,0,0,0,        64'h204, imem_word(64'h200), 64'h200, 64'h204, 1, 0, 0);
        add(0,1,0,0,        64'h208, NOP_INSTR,        64'h200, 64'h204, 0, 0, 0);
        add(0,0,0,0,        64'h20C, imem_word(64'h208), 64'h208, 64'h20C, 1, 0, 0);
        add(0,0,1,64'h203,  64'h200, NOP_INSTR,        64'h208, 64'h20C, 0, 1, 64'h203);
        add(0,0,0,0,        64'h204, imem_word(64'h200), 64'h200, 64'h204, 1, 1, 64'h203);
        add(0,0,1,64'h305,  64'h304, NOP_INSTR,        64'h200, 64'h204, 0, 1, 64'h203);
        add(1,1,0,0,        64'h304, NOP_INSTR,        64'h200, 64'h204, 0, 1, 64'h203);
        add(0,0,1,64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, NOP_INSTR,
            64'h200, 64'h204, 0, 1, 64'h203);
        add(0,0,0,0,        64'h0, imem_word(64'hFFFF_FFFF_FFFF_FFFC),
            64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1, 1, 64'h203);
        add(1,0,0,0,        64'h0, imem_word(64'hFFFF_FFFF_FFFF_FFFC),
            64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1, 1, 64'h203);

        reset = 1'b0;
        bus.stall = 1'b0; bus.flush = 1'b0; bus.br_taken = 1'b0; bus.br_target = 64'h0;
        #12;
        check_reset_state("reset");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.stall     = vecs[i].stall;
            bus.flush     = vecs[i].flush;
            bus.br_taken  = vecs[i].br;
            bus.br_target = vecs[i].tgt;
            @(posedge clk);
            #1;
            check($sformatf("v%0d imem_addr", i),   bus.imem_addr,          vecs[i].pc);
            check($sformatf("v%0d id_instr", i),    {32'h0, bus.id_instr},  {32'h0, vecs[i].instr});
            check($sformatf("v%0d id_pc", i),       bus.id_pc,              vecs[i].id_pc);
            check($sformatf("v%0d id_pc_plus4", i), bus.id_pc_plus4,        vecs[i].id_pc4);
            check($sformatf("v%0d id_valid", i),    {63'h0, bus.id_valid},  {63'h0, vecs[i].valid});
            check($sformatf("v%0d fault", i),       {63'h0, bus.fault},     {63'h0, vecs[i].fault});
            check($sformatf("v%0d fault_pc", i),    bus.fault_pc,           vecs[i].fault_pc);
        end

        // Async reset while stalled and faulted: state must clear before any clock edge.
        bus.stall = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        check_reset_state("async_reset");

        // Pending redirect during reset is ignored; after release RESET_PC is fetched.
        bus.stall = 1'b0; bus.br_taken = 1'b1; bus.br_target = 64'h500;
        @(posedge clk);
        #1;
        check_reset_state("held_reset");
        bus.br_taken = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("release id_pc",    bus.id_pc,             RESET_PC);
        check("release id_valid", {63'h0, bus.id_valid}, 64'h1);
        check("release imem_addr", bus.imem_addr,        RESET_PC + 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Pipelined instruction-fetch stage for the 64-bit LEGv8 CPU. Sits directly upstream of decode/control (main_control, datpath).
- Owns the program counter and drives the instruction-memory address.
- Captures the fetched word into an IF/ID pipeline register for decode to consume.
- Handles decode stall, pipeline flush and taken-branch redirect from downstream. Reports misaligned redirect targets as a sticky fault.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
NOP_INSTR, 32'hD503201F, instruction word inserted into IF/ID on bubble or flush.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
imem_addr  output  64  address to instruction memory; always equals current PC.
imem_instr  input  32  instruction word returned combinationally for imem_addr.
stall  input  1  decode cannot accept; hold PC and IF/ID.
flush  input  1  squash IF/ID contents (wrong-path instruction).
br_taken  input  1  redirect PC to br_target this cycle.
br_target  input  64  branch target (PC + SE(offset)<<2), computed downstream.
id_instr  output  32  IF/ID instruction.
id_pc  output  64  IF/ID PC of id_instr.
id_pc_plus4  output  64  IF/ID PC+4 of id_instr.
id_valid  output  1  IF/ID holds a real instruction.
fault  output  1  sticky: a misaligned redirect target was seen.
fault_pc  output  64  br_target that raised fault (first one only).

Behaviour:
- Reset (reset==0, async, overrides everything):
  - PC = RESET_PC.
  - id_instr = NOP_INSTR; id_pc = 0; id_pc_plus4 = 0.
  - id_valid = 0; fault = 0; fault_pc = 0.
- imem_addr = PC at all times; pc_plus4 = PC + 64'd4 with 64-bit wrap (FFFF_FFFF_FFFF_FFFC -> 0).
- Next-PC priority (high to low):
  - br_taken: PC <= {br_target[63:2], 2'b00}.
  - stall: PC held.
  - otherwise: PC <= pc_plus4.
- IF/ID update priority (high to low):
  - flush or br_taken: id_instr <= NOP_INSTR, id_valid <= 0; id_pc and id_pc_plus4 hold.
  - stall: all IF/ID fields hold.
  - otherwise: id_instr <= imem_instr, id_pc <= PC, id_pc_plus4 <= pc_plus4, id_valid <= 1.
- Latency: the word at PC appears on id_instr one clock after PC is presented; steady-state throughput is 1 instruction/cycle.
- Branch penalty:
  - The instruction fetched in the redirect cycle is discarded.
  - The first target-path instruction reaches IF/ID two edges after br_taken is sampled.
- Stall during redirect: br_taken still updates PC and bubbles IF/ID (redirect overrides stall for both).
- flush without br_taken: PC still advances normally unless stall is also high.
- Fault:
  - On any edge with br_taken=1 and br_target[1:0] != 0, set fault = 1.
  - If fault was previously 0, capture fault_pc <= br_target.
  - fault clears only on reset. PC still loads the aligned target.
- First cycle after reset release: id_valid = 0; RESET_PC is fetched and appears valid at the following edge (absent stall, flush or br_taken).
- Reset mid-stall or mid-redirect: async reset returns all state to reset values immediately; pending redirect is lost.
- No combinational path from stall, flush or br_taken to any output except via registers; imem_addr depends on PC register only.

Test Plan:
- Reset RESET_PC=0x100, release, imem returns 0x8B020020 at 0x100 and 0x91000421 at 0x104 -> edge1: id_instr=0x8B020020, id_pc=0x100, id_pc_plus4=0x104, id_valid=1; edge2: id_pc=0x104, imem_addr=0x108.
- stall=1 for 3 cycles at PC=0x108 -> imem_addr stays 0x108, IF/ID unchanged; after release, next edge loads the 0x108 instruction with id_pc=0x108.
- br_taken=1, br_target=0x40 at PC=0x110 -> next edge: imem_addr=0x40, id_valid=0, id_instr=NOP_INSTR; following edge: id_pc=0x40, id_valid=1.
- br_taken=1 and stall=1 together, target 0x200 -> PC=0x200, id_valid=0 (redirect wins); flush=1 alone -> id_valid=0 while PC advances by 4.
- br_taken with br_target=0x203 -> fault=1, fault_pc=0x203, PC=0x200; a later target 0x305 leaves fault_pc=0x203.
- PC at 0xFFFF_FFFF_FFFF_FFFC, no stall -> next PC=0x0, id_pc_plus4=0x0; assert reset low mid-stall -> outputs return to reset values without a clock edge.
